// File: rtl/bcd_down_counter.sv
// bcd_down_counter: presettable BCD down counter of DIGITS decades.
// Ports: clk, clr (async active-low), load/din (preset, clamped to 9),
//        en (decrement), wrap (00..0 -> 99..9 or hold), q/qb (count and
//        complement), zero (q == 0), bo (borrow out for cascading).
module bcd_down_counter #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   input  logic                en,
   input  logic                wrap,
   output logic [4*DIGITS-1:0] q,
   output logic [4*DIGITS-1:0] qb,
   output logic                zero,
   output logic                bo
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]    r_q;
   logic [W-1:0]    w_ld;
   logic [W-1:0]    w_dec;
   logic [DIGITS:0] w_brw;
   logic            w_zero;
   logic            w_step;

   // Borrow chain: digit i steps when every lower digit is zero.
   // The chain's final output is therefore the all-zero flag.
   assign w_brw[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      logic [3:0] w_d;
      logic [3:0] w_in;

      assign w_d  = r_q[4*g +: 4];
      assign w_in = din[4*g +: 4];

      assign w_ld[4*g +: 4] = (w_in > 4'd9) ? 4'd9 : w_in;

      always_comb begin
         w_dec[4*g +: 4] = w_d;
         if (w_brw[g]) begin
            if (w_d == 4'd0) w_dec[4*g +: 4] = 4'd9;
            else             w_dec[4*g +: 4] = w_d - 4'd1;
         end
      end

      assign w_brw[g+1] = w_brw[g] & (w_d == 4'd0);
   end

   assign w_zero = w_brw[DIGITS];

   // At all-zero without wrap the count saturates instead of rolling.
   assign w_step = en & ~(w_zero & ~wrap);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= w_ld;
      end else if (w_step) begin
         r_q <= w_dec;
      end
   end

   assign q    = r_q;
   assign qb   = ~r_q;
   assign zero = w_zero;
   assign bo   = en & w_zero & ~load;

endmodule
